queue_nd: RTL

Parametrised single-clock FIFO replacing the fixed 64-entry queue in the RISC core's message and DMA paths. Width, depth and almost-full threshold are generics. All `2**DEPTH_LOG2` entries are usable, and `dout` presents the head word combinationally (first-word fall-through). The block adds an occupancy count, an almost-full watermark and optional sticky overflow/underflow flags. Storage is a distributed-RAM array with one synchronous write port and one asynchronous read port.

---
 rtl/queue_nd.sv | 110 +++++++++++
 1 files changed

// File: rtl/queue_nd.sv
// Parametrised first-word-fall-through FIFO with occupancy count and almost-full watermark.
// Define QUEUE_ND_ERRFLAGS_EN to build the sticky ovf/udf error flags; otherwise they read 0.
module queue_nd #(
  parameter int unsigned WIDTH        = 1,
  parameter int unsigned DEPTH_LOG2   = 6,
  parameter int unsigned AFULL_MARGIN = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      din,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      dout,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  ovf,
  output logic                  udf
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CntFull  = (DEPTH_LOG2 + 1)'(Depth);
  localparam logic [DEPTH_LOG2:0]   CntAfull = (DEPTH_LOG2 + 1)'(Depth - AFULL_MARGIN);
  localparam logic [DEPTH_LOG2:0]   CntOne   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PtrOne   = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      mem [Depth];
  logic [DEPTH_LOG2-1:0] wa_q, wa_d;
  logic [DEPTH_LOG2-1:0] ra_q, ra_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  wr_ok, rd_ok;
  logic                  mem_we;

  // Status decode straight off the registered count.
  always_comb begin
    empty       = (count_q == '0);
    full        = (count_q == CntFull);
    almost_full = (count_q >= CntAfull);
    count       = count_q;
  end

  // A write at full is still accepted when a read frees the head slot in the same edge.
  always_comb begin
    wr_ok  = wr_en & (~full | rd_en);
    rd_ok  = rd_en & ~empty;
    mem_we = wr_ok & ~rst;
  end

  always_comb begin
    wa_d    = wa_q;
    ra_d    = ra_q;
    count_d = count_q;
    if (rst) begin
      wa_d    = '0;
      ra_d    = '0;
      count_d = '0;
    end else begin
      if (wr_ok) wa_d = wa_q + PtrOne;
      if (rd_ok) ra_d = ra_q + PtrOne;
      if (wr_ok && !rd_ok) begin
        count_d = count_q + CntOne;
      end else if (rd_ok && !wr_ok) begin
        count_d = count_q - CntOne;
      end
    end
  end

  always_ff @(posedge clk) begin
    wa_q    <= wa_d;
    ra_q    <= ra_d;
    count_q <= count_d;
  end

  // Distributed RAM: synchronous write, asynchronous read, contents never cleared.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wa_q] <= din;
  end

  assign dout = mem[ra_q];

`ifdef QUEUE_ND_ERRFLAGS_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (rst) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else begin
      if (wr_en && full && !rd_en) ovf_d = 1'b1;
      if (rd_en && empty)          udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    ovf_q <= ovf_d;
    udf_q <= udf_d;
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
`else
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif

endmodule
